// File: rtl/prio_rr_arbiter_pkg.sv
// Shared definitions for prio_rr_arbiter: state encoding, hold counter width,
// and the grant-index width helper used for the parameter sanity check.
package prio_rr_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE    = 1'b0,
    ARB_GRANTED = 1'b1
  } arb_state_e;

  localparam int HOLD_W = 16;

  // Returns max(1, ceil(log2(n))).
  function automatic int idx_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/prio_rr_arbiter_rr_pick.sv
// Combinational rotate-priority encoder: finds the first set bit of vec_i
// searching upward from start_i, wrapping modulo N_REQ.
module prio_rr_arbiter_rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] vec_i,
  input  logic [IDX_W-1:0] start_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o
);

  localparam int PW = IDX_W + 1;

  logic [PW-1:0] pos;

  // Walk offsets from the far end down so the nearest hit is written last.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    pos     = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      pos = {1'b0, start_i} + PW'(k);
      if (pos >= PW'(N_REQ)) pos = pos - PW'(N_REQ);
      if (vec_i[pos[IDX_W-1:0]]) begin
        found_o = 1'b1;
        idx_o   = pos[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/prio_rr_arbiter.sv
// Non-preemptive N-way arbiter: high-priority requesters by lowest index,
// normal requesters round-robin. Define ARB_TIMEOUT_EN for the hold-timeout.
module prio_rr_arbiter
  import prio_rr_arbiter_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int IDX_W    = 2,
  parameter int MAX_HOLD = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_REQ-1:0] req_i,
  input  logic [N_REQ-1:0] prio_i,
  output logic [N_REQ-1:0] grant_o,
  output logic             grant_valid_o,
  output logic [IDX_W-1:0] grant_idx_o
`ifdef ARB_TIMEOUT_EN
  ,
  output logic             hold_expired_o
`endif
);

  if (IDX_W != idx_width(N_REQ)) begin : g_bad_idx_w
    $error("IDX_W must equal max(1, ceil(log2(N_REQ)))");
  end
  if (N_REQ < 2 || N_REQ > 32) begin : g_bad_n_req
    $error("N_REQ must be in 2..32");
  end

  arb_state_e       state_q;
  logic [N_REQ-1:0] grant_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] rr_ptr_q;

  logic             owner_req;
  logic             owner_rel;
  logic             forced;
  logic             arb_edge;
  logic [N_REQ-1:0] cand;
  logic [N_REQ-1:0] hi;
  logic [N_REQ-1:0] lo;
  logic             hi_found;
  logic             lo_found;
  logic [IDX_W-1:0] hi_idx;
  logic [IDX_W-1:0] lo_idx;
  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic [N_REQ-1:0] win_onehot;
  logic [IDX_W-1:0] rr_next;

  assign owner_req = |(req_i & grant_q);
  assign owner_rel = (state_q == ARB_GRANTED) && !owner_req;

`ifdef ARB_TIMEOUT_EN
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  logic [HOLD_W-1:0] hold_cnt_q;
  logic              hold_expired_q;

  assign forced = (state_q == ARB_GRANTED) && owner_req &&
                  (hold_cnt_q == HOLD_LAST) && (|(req_i & ~grant_q));
`else
  assign forced = 1'b0;
`endif

  assign arb_edge = (state_q == ARB_IDLE) || owner_rel || forced;

  // grant_q is zero while idle, so this masks only the outgoing owner.
  assign cand = req_i & ~grant_q;
  assign hi   = cand & prio_i;
  assign lo   = cand & ~prio_i;

  prio_rr_arbiter_rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick_hi (
    .vec_i   (hi),
    .start_i ('0),
    .found_o (hi_found),
    .idx_o   (hi_idx)
  );

  prio_rr_arbiter_rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick_lo (
    .vec_i   (lo),
    .start_i (rr_ptr_q),
    .found_o (lo_found),
    .idx_o   (lo_idx)
  );

  assign win_found = hi_found || lo_found;
  assign win_idx   = hi_found ? hi_idx : lo_idx;
  assign rr_next   = (lo_idx == IDX_W'(N_REQ - 1)) ? '0 : lo_idx + 1'b1;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_onehot
    assign win_onehot[gi] = (win_idx == IDX_W'(gi));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ARB_IDLE;
      grant_q  <= '0;
      idx_q    <= '0;
      rr_ptr_q <= '0;
    end else if (arb_edge) begin
      if (win_found) begin
        state_q <= ARB_GRANTED;
        grant_q <= win_onehot;
        idx_q   <= win_idx;
        if (!hi_found) rr_ptr_q <= rr_next;
      end else begin
        state_q <= ARB_IDLE;
        grant_q <= '0;
        idx_q   <= '0;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hold_cnt_q     <= '0;
      hold_expired_q <= 1'b0;
    end else begin
      hold_expired_q <= forced;
      if (arb_edge) begin
        hold_cnt_q <= '0;
      end else if (hold_cnt_q != HOLD_LAST) begin
        hold_cnt_q <= hold_cnt_q + 1'b1;
      end
    end
  end

  assign hold_expired_o = hold_expired_q;
`endif

  assign grant_o       = grant_q;
  assign grant_valid_o = (state_q == ARB_GRANTED);
  assign grant_idx_o   = idx_q;

endmodule

// File: tb/tb_prio_rr_arbiter.sv
// Scoreboard bench for prio_rr_arbiter: a 4-requester and a 3-requester instance;
// the hold-timeout cases run when ARB_TIMEOUT_EN is defined.
module tb_prio_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req_a = 4'b0000, prio_a = 4'b0000, grant_a;
  logic       valid_a;
  logic [1:0] idx_a;
  logic [2:0] req_b = 3'b000, prio_b = 3'b000, grant_b;
  logic       valid_b;
  logic [1:0] idx_b;
`ifdef ARB_TIMEOUT_EN
  logic       hexp_a, hexp_b;
`endif

  always #5 clk = ~clk;

  prio_rr_arbiter #(.N_REQ(4), .IDX_W(2), .MAX_HOLD(4)) dut_a (
    .clk_i (clk), .rst_i (rst), .req_i (req_a), .prio_i (prio_a),
    .grant_o (grant_a), .grant_valid_o (valid_a), .grant_idx_o (idx_a)
`ifdef ARB_TIMEOUT_EN
    , .hold_expired_o (hexp_a)
`endif
  );

  prio_rr_arbiter #(.N_REQ(3), .IDX_W(2), .MAX_HOLD(4)) dut_b (
    .clk_i (clk), .rst_i (rst), .req_i (req_b), .prio_i (prio_b),
    .grant_o (grant_b), .grant_valid_o (valid_b), .grant_idx_o (idx_b)
`ifdef ARB_TIMEOUT_EN
    , .hold_expired_o (hexp_b)
`endif
  );

  typedef struct {
    string      name;
    bit         sel_b;
    logic [3:0] grant;
    logic [1:0] idx;
    logic       hexp;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input string what,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s: got %0h expected %0h", name, what, act, exp);
    end
  endtask

  // Monitor: one expected entry per transaction; the reset wake-up lets the
  // asynchronous reset be checked with no clock edge in between.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or posedge rst);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        if (!e.sel_b) begin
          $display("txn %-10s dut=a req=%b prio=%b grant=%b idx=%0d", e.name, req_a, prio_a, grant_a, idx_a);
          chk(e.name, "grant", 32'(grant_a), 32'(e.grant));
          chk(e.name, "idx", 32'(idx_a), 32'(e.idx));
          chk(e.name, "valid", 32'(valid_a), 32'(|e.grant));
`ifdef ARB_TIMEOUT_EN
          chk(e.name, "hold_expired", 32'(hexp_a), 32'(e.hexp));
`endif
        end else begin
          $display("txn %-10s dut=b req=%b prio=%b grant=%b idx=%0d", e.name, req_b, prio_b, grant_b, idx_b);
          chk(e.name, "grant", 32'({1'b0, grant_b}), 32'(e.grant));
          chk(e.name, "idx", 32'(idx_b), 32'(e.idx));
          chk(e.name, "valid", 32'(valid_b), 32'(|e.grant));
        end
      end
    end
  end

  task automatic sa(input string name, input logic [3:0] r, input logic [3:0] p,
                    input logic [3:0] eg, input logic [1:0] ei, input logic eh);
    @(negedge clk);
    rst = 1'b0; req_a = r; prio_a = p;
    q.push_back('{name, 1'b0, eg, ei, eh});
  endtask

  task automatic sb(input string name, input logic [2:0] r, input logic [2:0] p,
                    input logic [3:0] eg, input logic [1:0] ei);
    @(negedge clk);
    rst = 1'b0; req_b = r; prio_b = p;
    q.push_back('{name, 1'b1, eg, ei, 1'b0});
  endtask

  task automatic reset_now(input string name);
    @(negedge clk);
    q.push_back('{name, 1'b0, 4'b0000, 2'd0, 1'b0});
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  initial begin
    req_a = 4'b1111;
    reset_now("rst_hold");
    // Async reset mid-grant, then re-grant one edge after release
    sa("own2",      4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b0);
    reset_now("rst_async");
    sa("rst_rel",   4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b0);
    sa("drop",      4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0);
    reset_now("rst_idle");
    sa("idle",      4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0);
    // Round-robin rotation with zero idle cycles
    sa("rr0",       4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b0);
    sa("rr1",       4'b1110, 4'b0000, 4'b0010, 2'd1, 1'b0);
    sa("rr2",       4'b1101, 4'b0000, 4'b0100, 2'd2, 1'b0);
    sa("rr3",       4'b1011, 4'b0000, 4'b1000, 2'd3, 1'b0);
    sa("rr0b",      4'b0111, 4'b0000, 4'b0001, 2'd0, 1'b0);
    // High priority arrives: no preemption, wins at release, rr_ptr kept at 1
    sa("nopre1",    4'b1011, 4'b1000, 4'b0001, 2'd0, 1'b0);
    sa("nopre2",    4'b1011, 4'b1000, 4'b0001, 2'd0, 1'b0);
    sa("hiwin",     4'b1010, 4'b1000, 4'b1000, 2'd3, 1'b0);
    sa("rrkept",    4'b0011, 4'b0000, 4'b0010, 2'd1, 1'b0);
    // Owner 1 drops while req[3] rises
    sa("simul",     4'b1000, 4'b0000, 4'b1000, 2'd3, 1'b0);
    sa("hilow",     4'b0110, 4'b0110, 4'b0010, 2'd1, 1'b0);
    sa("rrafthi",   4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b0);
    sa("idle2",     4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0);
    // N_REQ=3 wrap
    sb("b_own1",    3'b010, 3'b000, 4'b0010, 2'd1);
    sb("b_idle",    3'b000, 3'b000, 4'b0000, 2'd0);
    sb("b_wrap",    3'b011, 3'b000, 4'b0001, 2'd0);
    sb("b_own1b",   3'b110, 3'b000, 4'b0010, 2'd1);
    sb("b_own2",    3'b101, 3'b000, 4'b0100, 2'd2);
    sb("b_mod",     3'b011, 3'b000, 4'b0001, 2'd0);
    sb("b_idle2",   3'b000, 3'b000, 4'b0000, 2'd0);
`ifdef ARB_TIMEOUT_EN
    sa("to_g0",     4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b0);
    for (int i = 0; i < 3; i++)
      sa("to_hold", 4'b0011, 4'b0000, 4'b0001, 2'd0, 1'b0);
    sa("to_force",  4'b0011, 4'b0000, 4'b0010, 2'd1, 1'b1);
    sa("to_after",  4'b0011, 4'b0000, 4'b0010, 2'd1, 1'b0);
    sa("to_g0b",    4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b0);
    for (int i = 0; i < 5; i++)
      sa("to_alone", 4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b0);
    sa("to_sat",    4'b0011, 4'b0000, 4'b0010, 2'd1, 1'b1);
    sa("to_idle",   4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0);
`else
    sa("hold_g0",   4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b0);
    for (int i = 0; i < 6; i++)
      sa("hold_long", 4'b0011, 4'b0000, 4'b0001, 2'd0, 1'b0);
    sa("hold_rel",  4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b0);
`endif
    @(negedge clk);
    @(negedge clk);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending entries expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prio_rr_arbiter.md
Name: prio_rr_arbiter

Overview:
- Parametrised N-requester successor to the two-input priority/normal arbiter in the LightIO I/O path.
- Grants exactly one requester at a time, and the grant is held until that requester drops its request.
- Requesters flagged high-priority win by fixed priority (lowest index first). Normal requesters are served round-robin.
- Sits between the packet sources (tx engines, LED/IRQ producers) and the shared pin/bus driver.

Parameters:
- N_REQ, default 4: number of requesters; legal range 2..32.
- IDX_W, default 2: grant index width; must equal max(1, ceil(log2(N_REQ))).
- MAX_HOLD, default 64: maximum grant length in cycles, used only with ARB_TIMEOUT_EN; legal range 2..65535.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  N_REQ  per-requester request level; held high for the whole transaction.
- prio  in  N_REQ  per-requester high-priority flag; sampled only at arbitration edges.
- grant  out  N_REQ  one-hot grant, or all zero.
- grant_valid  out  1  OR of grant.
- grant_idx  out  IDX_W  index of the current owner; 0 when grant_valid is 0.
- hold_expired  out  1  one-cycle pulse on forced release; present only with ARB_TIMEOUT_EN.

Behaviour:
- Reset (async assert, sync release):
  - grant=0, grant_valid=0, grant_idx=0, rr_ptr=0, state=IDLE.
  - hold_cnt=0 and hold_expired=0.
  - Reset mid-grant drops the grant immediately, without waiting for a clock edge.
- States are IDLE and GRANTED. All outputs are registered; no combinational path from req to grant.
- Arbitration edge: any rising edge where state=IDLE, or where state=GRANTED and the owner releases.
- Candidate set:
  - cand = req, with the releasing owner's bit masked.
  - hi = cand & prio; lo = cand & ~prio.
- Winner selection:
  - If hi != 0: winner = lowest set index of hi; rr_ptr unchanged.
  - Else if lo != 0: winner = first set bit of lo searching from rr_ptr upward with wrap (rr_ptr, rr_ptr+1, ..., N_REQ-1, 0, ...); rr_ptr <= (winner+1) mod N_REQ.
  - Else: state <= IDLE, grant <= 0.
  - With a winner: state <= GRANTED, grant <= onehot(winner), grant_idx <= winner.
- Latency:
  - req rise while IDLE: grant appears after 1 edge.
  - Release (owner req low at an edge): grant drops on that same edge and the next winner is granted on that same edge. Back-to-back ownership has zero idle cycles.
- While GRANTED and the owner's req is still high:
  - No change; non-preemptive, even when a high-priority req arrives.
  - prio changes are ignored until the next arbitration edge.
- Simultaneous events:
  - Several reqs rising on the same edge: one winner per the rules above.
  - Owner dropping while others rise: those others are candidates on that edge.
- A req pulse shorter than one cycle between edges is not captured.
- N_REQ not a power of two: the rr_ptr wrap is an explicit modulo. rr_ptr never holds a value >= N_REQ.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- With the macro:
  - hold_cnt (16 bits) clears on every new grant and increments each GRANTED cycle.
  - When hold_cnt = MAX_HOLD-1 and (req & ~owner) != 0, the edge is a forced arbitration edge: the owner is masked exactly as on a release, and hold_expired pulses 1 for one cycle.
  - If no other req is pending, the grant is kept and hold_cnt saturates at MAX_HOLD-1.
  - The expired owner may win again on a later edge.
- Without the macro: no hold_cnt, no hold_expired port; grants last indefinitely.

Decomposition:
- Shared package/header (definitions.v): state encodings ARB_IDLE=0 and ARB_GRANTED=1, and the function for the IDX_W check.
- One sub-module, rr_pick:
  - Purely combinational rotate-priority-encoder.
  - Inputs: vector and start pointer. Outputs: found and index.
  - Instantiated twice: once with start=0 for the fixed-priority class, once with start=rr_ptr for the round-robin class.

Test Plan:
- Reset check: N_REQ=4; assert reset mid-grant (owner 2) → grant=0000 with no clock edge; after release with req=0100 → grant=0100 after 1 edge.
- Round-robin fairness: req=1111, prio=0000, each owner drops req one cycle after its grant then re-raises → grant order 0,1,2,3,0; grant_idx matches; no idle cycle between owners.
- Priority class: owner 0 (normal) granted; then prio=1000 and req=1011 → no preemption. Owner 0 drops → grant=1000 on that edge; rr_ptr unchanged at 1.
- Non-power-of-two wrap: N_REQ=3, IDX_W=2, rr_ptr=2, req=011 → winner 0, rr_ptr becomes 1; grant_idx never reaches 3.
- Simultaneous release and request: owner 1 drops req on the same edge req[3] rises, req[1] now 0 → grant=1000 on that edge.
- ARB_TIMEOUT_EN, MAX_HOLD=4:
  - Owner 0 holds req and req[1]=1 → after 4 GRANTED cycles, grant moves to 0010 and hold_expired pulses once.
  - Same with req[1]=0 → owner 0 is kept and hold_expired stays 0.
